// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared types, constants and CRC-32 byte step for the Ethernet receive path
package eth_pkg;

    // Receive FSM states
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        PREAMBLE = 3'd1,
        HEADER   = 3'd2,
        PAYLOAD  = 3'd3,
        DROP     = 3'd4,
        WAIT_END = 3'd5
    } rx_state_t;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

    localparam logic [31:0] CRC_INIT    = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_POLY    = 32'hEDB8_8320;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    localparam int HDR_LEN = 14;
    localparam int FCS_LEN = 4;

    // One slot more than the FCS so the last payload byte is still held when the frame ends
    localparam int DLY_LEN = FCS_LEN + 1;

    // Reflected CRC-32 advanced by one byte, LSB first
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] dataByte);
        logic [31:0] c;
        c = crc ^ {24'h00_0000, dataByte};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/eth_crc32.sv
// rtl/eth_crc32.sv - registered byte-wide CRC-32 with init and enable
module eth_crc32
    import eth_pkg::*;
(
    input  logic        clkIn,
    input  logic        rstIn,
    input  logic        initIn,
    input  logic        enIn,
    input  logic [7:0]  dataIn,
    output logic [31:0] crcOut
);

    // Init wins over enable so a new frame can start on the same cycle an old one would update
    always_ff @(posedge clkIn) begin
        if (rstIn || initIn) begin
            crcOut <= CRC_INIT;
        end else if (enIn) begin
            crcOut <= crc32_byte(crcOut, dataIn);
        end
    end

endmodule

// File: rtl/eth_frame_rx.sv
// rtl/eth_frame_rx.sv - Ethernet frame receiver: preamble strip, header capture, filtering, FCS strip, status
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR        = 48'h02_00_00_00_00_01,
    parameter logic [15:0] ETH_TYPE_FILTER = 16'h0800,
    parameter int          MIN_FRAME_LEN   = 64,
    parameter int          MAX_FRAME_LEN   = 1518
) (
    input  logic        rxClkIn,
    input  logic        rstIn,
    input  logic [7:0]  dataIn,
    input  logic        dataValidIn,
    input  logic        dataLastIn,
    output logic [47:0] dstMacOut,
    output logic [47:0] srcMacOut,
    output logic [15:0] ethTypeOut,
    output logic        headerValidOut,
    output logic [7:0]  payloadOut,
    output logic        payloadValidOut,
    output logic        payloadLastOut,
    output logic        frameDoneOut,
    output logic        frameOkOut,
    output logic        crcErrOut,
    output logic        lenErrOut,
    output logic        droppedOut
);

    localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME_LEN);
    localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME_LEN);
    localparam logic [10:0] COUNT_MAX = 11'h7FF;
    localparam logic [10:0] HDR_LAST  = 11'(HDR_LEN - 1);
    localparam logic [2:0]  DLY_FULL  = 3'(DLY_LEN);

    rx_state_t    state;
    logic [10:0]  byteCount;
    logic [103:0] hdrShift;
    logic [111:0] hdrFull;
    logic [7:0]   dlyLine [DLY_LEN];
    logic [2:0]   dlyFill;
    logic         filterFail;
    logic [31:0]  crcValue;

    logic inFrame;
    logic sfdSeen;
    logic byteEn;
    logic hdrDone;
    logic frameEnd;
    logic macMatch;
    logic typeMatch;
    logic filterPass;

    // Bytes from the destination MAC through the FCS are the frame proper
    assign inFrame  = (state == HEADER) || (state == PAYLOAD) || (state == DROP);
    assign sfdSeen  = (state == PREAMBLE) && dataValidIn && (dataIn == SFD_BYTE);
    assign byteEn   = inFrame && dataValidIn;
    assign hdrDone  = (state == HEADER) && dataValidIn && (byteCount == HDR_LAST);
    assign frameEnd = inFrame && dataLastIn;

    // The 14th header byte is still on dataIn when the filter decides
    assign hdrFull    = {hdrShift, dataIn};
    assign macMatch   = (hdrFull[111:64] == MAC_ADDR) || (hdrFull[111:64] == BCAST_MAC);
    assign typeMatch  = (ETH_TYPE_FILTER == 16'h0000) || (hdrFull[15:0] == ETH_TYPE_FILTER);
    assign filterPass = macMatch && typeMatch;

    eth_crc32 crcUnit (
        .clkIn  (rxClkIn),
        .rstIn  (rstIn),
        .initIn (sfdSeen),
        .enIn   (byteEn),
        .dataIn (dataIn),
        .crcOut (crcValue)
    );

    // Frame-level state machine; every frame end returns to IDLE in the same cycle
    always_ff @(posedge rxClkIn) begin
        if (rstIn) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (dataValidIn && (dataIn == PREAMBLE_BYTE)) begin
                        state <= PREAMBLE;
                    end
                end
                PREAMBLE: begin
                    if (dataValidIn) begin
                        if (dataIn == SFD_BYTE) begin
                            state <= HEADER;
                        end else if (dataIn != PREAMBLE_BYTE) begin
                            state <= WAIT_END;
                        end
                    end
                end
                HEADER: begin
                    if (dataLastIn) begin
                        state <= IDLE;
                    end else if (hdrDone) begin
                        state <= filterPass ? PAYLOAD : DROP;
                    end
                end
                PAYLOAD, DROP, WAIT_END: begin
                    if (dataLastIn) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Saturating count of frame bytes, restarted at the SFD
    always_ff @(posedge rxClkIn) begin
        if (rstIn || sfdSeen) begin
            byteCount <= 11'd0;
        end else if (byteEn && (byteCount != COUNT_MAX)) begin
            byteCount <= byteCount + 11'd1;
        end
    end

    // Header shift register; published outputs only change when a full header lands
    always_ff @(posedge rxClkIn) begin
        if (rstIn) begin
            hdrShift       <= '0;
            dstMacOut      <= '0;
            srcMacOut      <= '0;
            ethTypeOut     <= '0;
            headerValidOut <= 1'b0;
            filterFail     <= 1'b0;
        end else begin
            headerValidOut <= 1'b0;
            if (sfdSeen) begin
                filterFail <= 1'b0;
            end
            if ((state == HEADER) && dataValidIn) begin
                hdrShift <= hdrFull[103:0];
            end
            if (hdrDone) begin
                dstMacOut      <= hdrFull[111:64];
                srcMacOut      <= hdrFull[63:16];
                ethTypeOut     <= hdrFull[15:0];
                headerValidOut <= 1'b1;
                filterFail     <= ~filterPass;
            end
        end
    end

    // Five-byte delay line: a byte leaves only once four newer bytes exist, so the FCS never escapes
    always_ff @(posedge rxClkIn) begin
        if (rstIn) begin
            for (int i = 0; i < DLY_LEN; i++) begin
                dlyLine[i] <= 8'h00;
            end
            dlyFill         <= 3'd0;
            payloadOut      <= 8'h00;
            payloadValidOut <= 1'b0;
            payloadLastOut  <= 1'b0;
        end else begin
            payloadValidOut <= 1'b0;
            payloadLastOut  <= 1'b0;
            if ((state == PAYLOAD) && dataLastIn) begin
                if (dlyFill == DLY_FULL) begin
                    payloadOut      <= dlyLine[DLY_LEN-1];
                    payloadValidOut <= 1'b1;
                    payloadLastOut  <= 1'b1;
                end
                dlyFill <= 3'd0;
            end else if ((state == PAYLOAD) && dataValidIn) begin
                if (dlyFill == DLY_FULL) begin
                    payloadOut      <= dlyLine[DLY_LEN-1];
                    payloadValidOut <= 1'b1;
                end else begin
                    dlyFill <= dlyFill + 3'd1;
                end
                for (int i = DLY_LEN - 1; i > 0; i--) begin
                    dlyLine[i] <= dlyLine[i-1];
                end
                dlyLine[0] <= dataIn;
            end else if (state != PAYLOAD) begin
                dlyFill <= 3'd0;
            end
        end
    end

    // Per-frame status, computed from the CRC and count that include the final FCS byte
    always_ff @(posedge rxClkIn) begin
        if (rstIn) begin
            frameDoneOut <= 1'b0;
            frameOkOut   <= 1'b0;
            crcErrOut    <= 1'b0;
            lenErrOut    <= 1'b0;
            droppedOut   <= 1'b0;
        end else begin
            frameDoneOut <= 1'b0;
            if (frameEnd) begin
                frameDoneOut <= 1'b1;
                crcErrOut    <= (crcValue != CRC_RESIDUE);
                lenErrOut    <= (byteCount < MIN_LEN) || (byteCount > MAX_LEN);
                droppedOut   <= filterFail;
                frameOkOut   <= (crcValue == CRC_RESIDUE) && (byteCount >= MIN_LEN) &&
                                (byteCount <= MAX_LEN) && !filterFail;
            end
        end
    end

endmodule

// File: tb/tb_eth_frame_rx.sv
// tb/tb_eth_frame_rx.sv - randomized self-checking bench for eth_frame_rx against a frame-level model
module tb_eth_frame_rx;

    localparam logic [47:0] MY_MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] BCAST  = 48'hFFFF_FFFF_FFFF;

    logic        rxClkIn = 1'b0;
    logic        rstIn;
    logic [7:0]  dataIn;
    logic        dataValidIn;
    logic        dataLastIn;

    logic [47:0] aDst, aSrc, bDst, bSrc;
    logic [15:0] aType, bType;
    logic [7:0]  aPay, bPay;
    logic        aHdrV, aPayV, aPayL, aDone, aOk, aCrc, aLen, aDrop;
    logic        bHdrV, bPayV, bPayL, bDone, bOk, bCrc, bLen, bDrop;

    always #5 rxClkIn = ~rxClkIn;

    eth_frame_rx dutA (
        .rxClkIn(rxClkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
        .dataLastIn(dataLastIn), .dstMacOut(aDst), .srcMacOut(aSrc), .ethTypeOut(aType),
        .headerValidOut(aHdrV), .payloadOut(aPay), .payloadValidOut(aPayV),
        .payloadLastOut(aPayL), .frameDoneOut(aDone), .frameOkOut(aOk), .crcErrOut(aCrc),
        .lenErrOut(aLen), .droppedOut(aDrop)
    );

    eth_frame_rx #(.ETH_TYPE_FILTER(16'h0000)) dutB (
        .rxClkIn(rxClkIn), .rstIn(rstIn), .dataIn(dataIn), .dataValidIn(dataValidIn),
        .dataLastIn(dataLastIn), .dstMacOut(bDst), .srcMacOut(bSrc), .ethTypeOut(bType),
        .headerValidOut(bHdrV), .payloadOut(bPay), .payloadValidOut(bPayV),
        .payloadLastOut(bPayL), .frameDoneOut(bDone), .frameOkOut(bOk), .crcErrOut(bCrc),
        .lenErrOut(bLen), .droppedOut(bDrop)
    );

    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Observed streams, accumulated for the whole run
    logic [7:0] obsPayA[$];
    logic [7:0] obsPayB[$];
    logic [3:0] obsStatA[$];
    logic [3:0] obsStatB[$];
    int         obsLastA[$];
    int         obsHdrA = 0;

    always @(negedge rxClkIn) begin
        if (aPayV) obsPayA.push_back(aPay);
        if (aPayL) obsLastA.push_back((aDone && aPayV) ? obsPayA.size() - 1 : -2);
        if (aHdrV) obsHdrA++;
        if (aDone) obsStatA.push_back({aOk, aCrc, aLen, aDrop});
        if (bPayV) obsPayB.push_back(bPay);
        if (bDone) obsStatB.push_back({bOk, bCrc, bLen, bDrop});
    end

    // Expected streams from the model
    logic [7:0]  expPayA[$];
    logic [7:0]  expPayB[$];
    logic [3:0]  expStatA[$];
    logic [3:0]  expStatB[$];
    int          expLastA[$];
    int          expHdr = 0;
    logic [47:0] lastDst = '0;
    logic [47:0] lastSrc = '0;
    logic [15:0] lastType = '0;
    int ptrPayA = 0, ptrPayB = 0, ptrStatA = 0, ptrStatB = 0, ptrLastA = 0;

    logic [7:0] frm [0:1599];
    int         frmLen;
    bit         frmBad;

    function automatic logic [31:0] crcByte(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        return r;
    endfunction

    task automatic buildFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                              input int payLen, input bit corrupt, input bit randPay);
        logic [31:0] c;
        for (int i = 0; i < 6; i++) begin
            frm[i]     = dst[47-8*i -: 8];
            frm[6 + i] = src[47-8*i -: 8];
        end
        frm[12] = typ[15:8];
        frm[13] = typ[7:0];
        for (int i = 0; i < payLen; i++) frm[14 + i] = randPay ? 8'($urandom) : 8'(i);
        c = 32'hFFFFFFFF;
        for (int i = 0; i < 14 + payLen; i++) c = crcByte(c, frm[i]);
        c = ~c;
        for (int j = 0; j < 4; j++) frm[14 + payLen + j] = c[8*j +: 8];
        if (corrupt) frm[14 + payLen][0] = ~frm[14 + payLen][0];
        frmLen = 18 + payLen;
        frmBad = corrupt;
    endtask

    // Frame-level expectations: filter, length, CRC verdict, and the bytes between header and FCS
    task automatic modelFrame(input int abortAt);
        logic [47:0] dst;
        logic [15:0] typ;
        bit macOk, passA, passB, lenBad;
        dst = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
        typ = {frm[12], frm[13]};
        macOk = (dst == MY_MAC) || (dst == BCAST);
        passA = macOk && (typ == 16'h0800);
        passB = macOk;
        lenBad = (frmLen < 64) || (frmLen > 1518);
        lastDst = dst;
        lastSrc = {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]};
        lastType = typ;
        expHdr++;
        if (abortAt >= 0) begin
            // A byte only leaves once five later bytes have arrived
            for (int i = 14; i <= abortAt - 6; i++) begin
                if (passA) expPayA.push_back(frm[i]);
                if (passB) expPayB.push_back(frm[i]);
            end
            return;
        end
        expStatA.push_back({!frmBad && !lenBad && passA, frmBad, lenBad, !passA});
        expStatB.push_back({!frmBad && !lenBad && passB, frmBad, lenBad, !passB});
        if (frmLen - 14 >= 5) begin
            for (int i = 14; i < frmLen - 4; i++) begin
                if (passA) expPayA.push_back(frm[i]);
                if (passB) expPayB.push_back(frm[i]);
            end
            if (passA) expLastA.push_back(expPayA.size() - 1);
        end
    endtask

    task automatic driveByte(input logic [7:0] b);
        @(posedge rxClkIn);
        #1;
        dataValidIn = 1'b1;
        dataIn      = b;
        dataLastIn  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge rxClkIn);
            #1;
            dataValidIn = 1'b0;
            dataIn      = 8'h00;
            dataLastIn  = 1'b0;
        end
    endtask

    task automatic driveFrame(input int abortAt);
        for (int i = 0; i < 7; i++) driveByte(8'h55);
        driveByte(8'hD5);
        for (int i = 0; i < frmLen; i++) begin
            if (i == abortAt) begin
                @(posedge rxClkIn);
                #1;
                rstIn       = 1'b1;
                dataValidIn = 1'b0;
                @(posedge rxClkIn);
                #1;
                rstIn = 1'b0;
                return;
            end
            driveByte(frm[i]);
        end
        @(posedge rxClkIn);
        #1;
        dataValidIn = 1'b0;
        dataIn      = 8'h00;
        dataLastIn  = 1'b1;
    endtask

    task automatic sendFrame(input logic [47:0] dst, input logic [47:0] src, input logic [15:0] typ,
                             input int payLen, input bit corrupt, input bit randPay);
        buildFrame(dst, src, typ, payLen, corrupt, randPay);
        modelFrame(-1);
        driveFrame(-1);
    endtask

    task automatic verifyAll(input string tag);
        idle(4);
        @(negedge rxClkIn);
        checkValue({tag, "_statA_n"}, 64'(obsStatA.size()), 64'(expStatA.size()));
        for (int i = ptrStatA; i < expStatA.size() && i < obsStatA.size(); i++)
            checkValue({tag, "_statA"}, 64'(obsStatA[i]), 64'(expStatA[i]));
        ptrStatA = expStatA.size();
        checkValue({tag, "_statB_n"}, 64'(obsStatB.size()), 64'(expStatB.size()));
        for (int i = ptrStatB; i < expStatB.size() && i < obsStatB.size(); i++)
            checkValue({tag, "_statB"}, 64'(obsStatB[i]), 64'(expStatB[i]));
        ptrStatB = expStatB.size();
        checkValue({tag, "_payA_n"}, 64'(obsPayA.size()), 64'(expPayA.size()));
        for (int i = ptrPayA; i < expPayA.size() && i < obsPayA.size(); i++)
            checkValue({tag, "_payA"}, 64'(obsPayA[i]), 64'(expPayA[i]));
        ptrPayA = expPayA.size();
        checkValue({tag, "_payB_n"}, 64'(obsPayB.size()), 64'(expPayB.size()));
        for (int i = ptrPayB; i < expPayB.size() && i < obsPayB.size(); i++)
            checkValue({tag, "_payB"}, 64'(obsPayB[i]), 64'(expPayB[i]));
        ptrPayB = expPayB.size();
        checkValue({tag, "_lastA_n"}, 64'(obsLastA.size()), 64'(expLastA.size()));
        for (int i = ptrLastA; i < expLastA.size() && i < obsLastA.size(); i++)
            checkValue({tag, "_lastA_pos"}, 64'(obsLastA[i]), 64'(expLastA[i]));
        ptrLastA = expLastA.size();
        checkValue({tag, "_hdr_n"}, 64'(obsHdrA), 64'(expHdr));
        checkValue({tag, "_dst"}, 64'(aDst), 64'(lastDst));
        checkValue({tag, "_src"}, 64'(aSrc), 64'(lastSrc));
        checkValue({tag, "_type"}, 64'(aType), 64'(lastType));
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_dst"}, 64'(aDst), 64'd0);
        checkValue({tag, "_src"}, 64'(aSrc), 64'd0);
        checkValue({tag, "_misc"}, 64'({aType, aPay, aHdrV, aPayV, aPayL, aDone, aOk, aCrc, aLen, aDrop}), 64'd0);
    endtask

    logic [47:0] rDst;
    logic [15:0] rType;
    int          nFrames;
    int          rLen;
    bit          rBad;

    initial begin
        rstIn       = 1'b1;
        dataIn      = 8'h00;
        dataValidIn = 1'b0;
        dataLastIn  = 1'b0;
        idle(3);
        @(negedge rxClkIn);
        checkAllZero("reset");
        rstIn = 1'b0;
        idle(2);

        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 46, 1'b0, 1'b0);
        verifyAll("good");
        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 46, 1'b1, 1'b0);
        verifyAll("badfcs");
        sendFrame(48'h02_00_00_00_00_99, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 46, 1'b0, 1'b0);
        verifyAll("wrongmac");
        sendFrame(BCAST, 48'h11_22_33_44_55_66, 16'h86DD, 50, 1'b0, 1'b1);
        verifyAll("bcast86dd");
        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 42, 1'b0, 1'b0);
        verifyAll("runt60");
        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 45, 1'b0, 1'b1);
        verifyAll("len63");
        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 0, 1'b0, 1'b1);
        verifyAll("len18");
        sendFrame(MY_MAC, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 1500, 1'b0, 1'b1);
        verifyAll("len1518");
        sendFrame(BCAST, 48'h0A_0B_0C_0D_0E_0F, 16'h0800, 1501, 1'b0, 1'b1);
        verifyAll("len1519");

        // Two frames with no idle cycles, then a third cut off by reset mid-payload
        sendFrame(MY_MAC, 48'hA1_A2_A3_A4_A5_A6, 16'h0800, 46, 1'b0, 1'b1);
        sendFrame(BCAST, 48'hB1_B2_B3_B4_B5_B6, 16'h0800, 48, 1'b0, 1'b1);
        buildFrame(MY_MAC, 48'hC1_C2_C3_C4_C5_C6, 16'h0800, 46, 1'b0, 1'b1);
        modelFrame(20);
        driveFrame(20);
        @(negedge rxClkIn);
        checkAllZero("midrst");
        lastDst  = '0;
        lastSrc  = '0;
        lastType = '0;
        verifyAll("b2b");

        for (int burst = 0; burst < 12; burst++) begin
            nFrames = $urandom_range(1, 3);
            for (int f = 0; f < nFrames; f++) begin
                case ($urandom_range(0, 3))
                    0:       rDst = MY_MAC;
                    1:       rDst = BCAST;
                    2:       rDst = {16'h0200, 32'($urandom)};
                    default: rDst = {40'h02_00_00_00_00, 8'($urandom_range(0, 3))};
                endcase
                case ($urandom_range(0, 2))
                    0:       rType = 16'h0800;
                    1:       rType = 16'h86DD;
                    default: rType = 16'($urandom);
                endcase
                rLen = $urandom_range(0, 70);
                rBad = ($urandom_range(0, 3) == 0);
                sendFrame(rDst, {16'h0A0B, 32'($urandom)}, rType, rLen, rBad, 1'b1);
                if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 2));
            end
            verifyAll("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/eth_frame_rx.md
Name: eth_frame_rx

Overview:
Byte-stream Ethernet frame receiver that sits directly downstream of the RGMII RX MAC, in the rxClkIn domain. It strips the preamble and SFD, captures the destination MAC, source MAC and EtherType, and applies address and EtherType filters. It streams the payload with the 4-byte FCS removed, checks CRC-32 and frame length, and reports a per-frame status pulse to the order-book logic.

Parameters:
MAC_ADDR, 48'h02_00_00_00_00_01, unicast address accepted in addition to broadcast FF:FF:FF:FF:FF:FF
ETH_TYPE_FILTER, 16'h0800, EtherType accepted; 16'h0000 accepts any type
MIN_FRAME_LEN, 64, minimum bytes from destination MAC through FCS inclusive
MAX_FRAME_LEN, 1518, maximum bytes from destination MAC through FCS inclusive

Ports:
rxClkIn  in  1  RX clock from the PHY (the single clock)
rstIn  in  1  synchronous, active-high reset
dataIn  in  8  byte from the RGMII MAC
dataValidIn  in  1  dataIn is valid; contiguous within a frame
dataLastIn  in  1  single-cycle pulse the cycle after the final valid byte
dstMacOut  out  48  captured destination MAC
srcMacOut  out  48  captured source MAC
ethTypeOut  out  16  captured EtherType
headerValidOut  out  1  1-cycle pulse when all 14 header bytes are captured
payloadOut  out  8  payload byte
payloadValidOut  out  1  payloadOut valid
payloadLastOut  out  1  final payload byte of the frame
frameDoneOut  out  1  1-cycle status-valid pulse, once per frame
frameOkOut  out  1  CRC good, length in range and not filtered
crcErrOut  out  1  FCS mismatch
lenErrOut  out  1  length < MIN_FRAME_LEN or > MAX_FRAME_LEN
droppedOut  out  1  frame failed the address or EtherType filter

Behaviour:
- Reset (synchronous, active-high): every output is 0, FSM goes to IDLE, the byte counter and delay line are cleared, and CRC = 32'hFFFFFFFF. Reset mid-frame abandons the frame with no frameDoneOut.
- FSM states and transitions:
  - IDLE: dataValidIn with dataIn=8'h55 -> PREAMBLE.
  - PREAMBLE: 8'h55 stays. 8'hD5 after at least 1 byte of 8'h55 -> HEADER. Any other byte -> WAIT_END.
  - HEADER: bytes 0..13 are stored big-endian (dst, src, type). On byte 13, headerValidOut pulses the next cycle and the filter is evaluated: a pass -> PAYLOAD, a fail -> DROP.
  - PAYLOAD: bytes enter the 5-byte delay line.
  - DROP: bytes are counted and CRC'd but none are emitted.
  - WAIT_END: bytes are ignored until dataLastIn, then -> IDLE with no status pulse.
- dataLastIn in HEADER, PAYLOAD or DROP ends the frame and goes to IDLE. dataLastIn in IDLE or PREAMBLE is ignored.
- CRC: reflected CRC-32 (poly 0xEDB88320, LSB-first), init 32'hFFFFFFFF, updated one byte per cycle over every byte from dst MAC through FCS. A good frame leaves residue 32'hDEBB20E3.
- Byte counter: 11 bits, saturating at 2047, counting dst MAC through FCS.
- FCS stripping via the 5-byte delay line:
  - When a byte enters a full line, the oldest byte is output with payloadValidOut=1 one cycle later.
  - On dataLastIn, if the line holds 5 bytes, the oldest is output with payloadValidOut=1 and payloadLastOut=1 in the next cycle. The remaining 4 (FCS) are discarded and the line cleared.
  - If the line holds fewer than 5 bytes, no payloadLastOut is issued.
- Status: frameDoneOut pulses the cycle after dataLastIn, coincident with payloadLastOut when one is issued. On that cycle:
  - crcErrOut = (residue != DEBB20E3)
  - lenErrOut = (count < MIN or count > MAX)
  - droppedOut = filter failed
  - frameOkOut = none of the three
  - The status flags hold until the next frameDoneOut.
- Header outputs hold until the next headerValidOut.
- Filter pass requires dst == MAC_ADDR or dst == broadcast, AND (ETH_TYPE_FILTER == 0 or type == ETH_TYPE_FILTER).
- Back-to-back frames: dataLastIn followed by the next 8'h55 in the following cycle must be accepted. Flush and IDLE entry complete in the dataLastIn cycle.
- Oversize frames keep streaming; the error is reported only at frameDoneOut.

Decomposition:
- Package eth_pkg holds:
  - State enum rx_state_t: IDLE, PREAMBLE, HEADER, PAYLOAD, DROP, WAIT_END.
  - Constants PREAMBLE_BYTE=8'h55, SFD_BYTE=8'hD5, BCAST_MAC, CRC_INIT, CRC_POLY, CRC_RESIDUE, HDR_LEN=14, FCS_LEN=4.
  - Function crc32_byte(crc, byte).
- One sub-module, eth_crc32: registered CRC with init/enable, reusable by a future TX path.

Test Plan:
- 7x55, D5, dst=MAC_ADDR, src=0A:0B:0C:0D:0E:0F, type 0800, 46 bytes 00..2D, correct FCS -> headerValidOut once; 46 payload bytes 00..2D; payloadLastOut on 2D; frameOkOut=1, crcErrOut=0, lenErrOut=0.
- Same frame with FCS byte 0 bit 0 flipped -> identical payload stream; frameDoneOut with crcErrOut=1, frameOkOut=0.
- dst=02:00:00:00:00:99 -> droppedOut=1, payloadValidOut never asserted, frameDoneOut=1.
- Broadcast dst with type 86DD -> droppedOut=1. Repeat with ETH_TYPE_FILTER=0 -> frameOkOut=1.
- Runt (dst through FCS = 60 bytes, valid CRC) -> 42 payload bytes; lenErrOut=1, frameOkOut=0.
- Back-to-back frames with 0 idle cycles, plus rstIn asserted mid-payload of a third frame -> two correct status pulses; after reset all outputs 0 and no third frameDoneOut.
